// File: rtl/iob_normalizer_pkg.sv
// Shared types for the leading-zero normalizer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iob_normalizer_pkg;

   // Which end of the word the zero/one counter scans from.
   typedef enum logic {
      CTLS_LEADING  = 1'b0,
      CTLS_TRAILING = 1'b1
   } ctls_mode_e;

   // Symbol counted by the normalizer's counter instance.
   localparam logic CTLS_SYM_ZERO = 1'b0;

endpackage

// File: rtl/iob_normalizer_ctls.sv
// Counts leading or trailing SYMBOL bits of a word; W means every bit matches.
// Latency: combinational.
// Backpressure: none, pure function of data_i.
//   data_i : word to scan
//   cnt_o  : run length of SYMBOL from the selected end, 0..W
module iob_ctls
   import iob_normalizer_pkg::*;
#(
   parameter int         W      = 8,
   parameter ctls_mode_e MODE   = CTLS_LEADING,
   parameter logic       SYMBOL = CTLS_SYM_ZERO,
   localparam int        CW     = $clog2(W) + 1
) (
   input  logic [W-1:0]  data_i,
   output logic [CW-1:0] cnt_o
);

   logic found;

   // Walk from the selected end; the first non-SYMBOL bit fixes the count.
   always_comb begin
      cnt_o = CW'(W);
      found = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (!found) begin
            if (data_i[(MODE == CTLS_LEADING) ? (W - 1 - i) : i] != SYMBOL) begin
               cnt_o = CW'(i);
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/iob_normalizer.sv
// Two-stage leading-zero normalizer: shift word left until MSB=1, subtract shift from exponent.
// Latency: 2 edges acceptance->valid_o, 1 beat/cycle, capacity 2 beats.
// Backpressure: ready_o low only when both stages full and ready_i low; cke_i=0 freezes all.
//   clk_i/cke_i/rst_n_i : clock, clock enable, synchronous active-low reset
//   valid_i/ready_o/data_i/exp_i : input beat
//   valid_o/ready_i/data_o/exp_o/shift_o/zero_o/denorm_o : normalized output beat
module iob_normalizer
   import iob_normalizer_pkg::*;
#(
   parameter int  W   = 8,
   parameter int  EW  = 8,
   localparam int LZW = $clog2(W) + 1
) (
   input  logic           clk_i,
   input  logic           cke_i,
   input  logic           rst_n_i,
   input  logic           valid_i,
   output logic           ready_o,
   input  logic [W-1:0]   data_i,
   input  logic [EW-1:0]  exp_i,
   output logic           valid_o,
   input  logic           ready_i,
   output logic [W-1:0]   data_o,
   output logic [EW-1:0]  exp_o,
   output logic [LZW-1:0] shift_o,
   output logic           zero_o,
   output logic           denorm_o
);

   // Exponent and count are compared at a common width so neither truncates.
   localparam int CMPW = (EW > LZW) ? EW : LZW;

   logic           v1_q, v1_d;
   logic           v2_q, v2_d;
   logic [W-1:0]   s1_data_q, s1_data_d;
   logic [EW-1:0]  s1_exp_q, s1_exp_d;
   logic [W-1:0]   s2_data_q, s2_data_d;
   logic [EW-1:0]  s2_exp_q, s2_exp_d;
   logic [LZW-1:0] s2_shift_q, s2_shift_d;
   logic           s2_zero_q, s2_zero_d;
   logic           s2_denorm_q, s2_denorm_d;

   logic           accept, fire2, adv2;
   logic [LZW-1:0] lz, sh;
   logic [CMPW-1:0] lz_ext, exp_ext, sh_ext;
   logic           clamp, is_zero;

   iob_ctls #(
      .W      (W),
      .MODE   (CTLS_LEADING),
      .SYMBOL (CTLS_SYM_ZERO)
   ) u_ctls (
      .data_i (s1_data_q),
      .cnt_o  (lz)
   );

   // Depends only on registered occupancy, ready_i and cke_i; never on valid_i.
   assign ready_o = cke_i & (~v1_q | ~v2_q | ready_i);

   always_comb begin
      accept  = valid_i & ready_o;
      fire2   = cke_i & v1_q & (~v2_q | ready_i);
      adv2    = cke_i & v2_q & ready_i;

      // The shift is capped by the exponent so the exponent never wraps below 0.
      lz_ext  = CMPW'(lz);
      exp_ext = CMPW'(s1_exp_q);
      clamp   = lz_ext > exp_ext;
      sh_ext  = clamp ? exp_ext : lz_ext;
      sh      = LZW'(sh_ext);
      is_zero = (s1_data_q == '0);

      v1_d        = accept | (v1_q & ~fire2);
      v2_d        = fire2 | (v2_q & ~adv2);
      s1_data_d   = s1_data_q;
      s1_exp_d    = s1_exp_q;
      s2_data_d   = s2_data_q;
      s2_exp_d    = s2_exp_q;
      s2_shift_d  = s2_shift_q;
      s2_zero_d   = s2_zero_q;
      s2_denorm_d = s2_denorm_q;

      if (accept) begin
         s1_data_d = data_i;
         s1_exp_d  = exp_i;
      end

      if (fire2) begin
         if (is_zero) begin
            // All-zero word reports the full width as its shift and a zero exponent.
            s2_data_d   = '0;
            s2_exp_d    = '0;
            s2_shift_d  = LZW'(W);
            s2_zero_d   = 1'b1;
            s2_denorm_d = 1'b0;
         end else begin
            s2_data_d   = s1_data_q << sh;
            s2_exp_d    = EW'(exp_ext - sh_ext);
            s2_shift_d  = sh;
            s2_zero_d   = 1'b0;
            s2_denorm_d = clamp;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         s1_data_q   <= '0;
         s1_exp_q    <= '0;
         s2_data_q   <= '0;
         s2_exp_q    <= '0;
         s2_shift_q  <= '0;
         s2_zero_q   <= 1'b0;
         s2_denorm_q <= 1'b0;
      end else begin
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         s1_data_q   <= s1_data_d;
         s1_exp_q    <= s1_exp_d;
         s2_data_q   <= s2_data_d;
         s2_exp_q    <= s2_exp_d;
         s2_shift_q  <= s2_shift_d;
         s2_zero_q   <= s2_zero_d;
         s2_denorm_q <= s2_denorm_d;
      end
   end

   assign valid_o  = v2_q;
   assign data_o   = s2_data_q;
   assign exp_o    = s2_exp_q;
   assign shift_o  = s2_shift_q;
   assign zero_o   = s2_zero_q;
   assign denorm_o = s2_denorm_q;

endmodule

// File: tb/tb_iob_normalizer.sv
// Self-checking bench for iob_normalizer (W=8, EW=8).
// Latency: n/a.
// Backpressure: ready_i driven directed or random per phase.
module tb_iob_normalizer;

   logic       clk = 1'b0;
   logic       cke_i = 1'b1;
   logic       rst_n_i = 1'b0;
   logic       valid_i = 1'b0;
   logic       ready_o;
   logic [7:0] data_i = '0;
   logic [7:0] exp_i = '0;
   logic       valid_o;
   logic       ready_i = 1'b0;
   logic [7:0] data_o;
   logic [7:0] exp_o;
   logic [3:0] shift_o;
   logic       zero_o;
   logic       denorm_o;

   iob_normalizer #(.W(8), .EW(8)) dut (
      .clk_i    (clk),
      .cke_i    (cke_i),
      .rst_n_i  (rst_n_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data_i   (data_i),
      .exp_i    (exp_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .data_o   (data_o),
      .exp_o    (exp_o),
      .shift_o  (shift_o),
      .zero_o   (zero_o),
      .denorm_o (denorm_o)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic [7:0] e;
      logic [3:0] sh;
      logic       z;
      logic       dn;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;
   int   rdy_mode = 2;   // 0 random, 1 held high, 2 held low

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: shift left until MSB is set, but never by more than the exponent.
   function automatic exp_t model(input logic [7:0] d, input logic [7:0] e);
      exp_t r;
      int   lz = 0;
      int   sh;
      while (lz < 8 && d[7 - lz] == 1'b0) lz++;
      if (d == 8'h00) begin
         r.d = 8'h00; r.e = 8'h00; r.sh = 4'd8; r.z = 1'b1; r.dn = 1'b0;
      end else begin
         sh   = (lz > int'(e)) ? int'(e) : lz;
         r.d  = 8'(int'(d) << sh);
         r.e  = 8'(int'(e) - sh);
         r.sh = 4'(sh);
         r.z  = 1'b0;
         r.dn = (lz > int'(e));
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rdy_mode == 0) ready_i = 1'($urandom_range(0, 1));
   end

   // Monitor: every retiring output beat is checked against the oldest expectation.
   always begin
      @(negedge clk);
      #2;
      if (rst_n_i && cke_i && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_data",   int'(data_o),   int'(mon_e.d));
            chk("sb_exp",    int'(exp_o),    int'(mon_e.e));
            chk("sb_shift",  int'(shift_o),  int'(mon_e.sh));
            chk("sb_zero",   int'(zero_o),   int'(mon_e.z));
            chk("sb_denorm", int'(denorm_o), int'(mon_e.dn));
         end
      end
   end

   task automatic set_rdy(input int m);
      @(posedge clk);
      #1;
      rdy_mode = m;
      if (m == 1) ready_i = 1'b1;
      if (m == 2) ready_i = 1'b0;
   endtask

   task automatic offer(input logic [7:0] d, input logic [7:0] e, output bit acc);
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = d;
      exp_i   = e;
      #1;
      acc = ready_o && rst_n_i;
      if (acc) exp_q.push_back(model(d, e));
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] e);
      bit acc = 1'b0;
      for (int k = 0; k < 100; k++) begin
         offer(d, e, acc);
         if (acc) break;
      end
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic idle();
      @(negedge clk);
      valid_i = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
         #3;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   task automatic directed(input logic [7:0] d, input logic [7:0] e, input logic [7:0] rd,
                           input logic [7:0] re, input logic [3:0] rs, input logic rz,
                           input logic rdn);
      set_rdy(1);
      send(d, e);
      @(negedge clk);
      valid_i = 1'b0;
      #2;
      chk("lat_edge1_valid", int'(valid_o), 0);
      @(negedge clk);
      #2;
      chk("lat_edge2_valid", int'(valid_o), 1);
      chk("dir_data",   int'(data_o),   int'(rd));
      chk("dir_exp",    int'(exp_o),    int'(re));
      chk("dir_shift",  int'(shift_o),  int'(rs));
      chk("dir_zero",   int'(zero_o),   int'(rz));
      chk("dir_denorm", int'(denorm_o), int'(rdn));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      // Reset state
      repeat (2) @(negedge clk);
      #2;
      chk("rst_valid",  int'(valid_o),  0);
      chk("rst_data",   int'(data_o),   0);
      chk("rst_exp",    int'(exp_o),    0);
      chk("rst_shift",  int'(shift_o),  0);
      chk("rst_zero",   int'(zero_o),   0);
      chk("rst_denorm", int'(denorm_o), 0);
      @(negedge clk);
      rst_n_i = 1'b1;
      #2;
      chk("rst_ready", int'(ready_o), 1);

      // Directed values with latency check
      directed(8'h01, 8'd10, 8'h80, 8'd3, 4'd7, 1'b0, 1'b0);
      directed(8'h00, 8'd5,  8'h00, 8'd0, 4'd8, 1'b1, 1'b0);
      directed(8'h10, 8'd2,  8'h40, 8'd0, 4'd2, 1'b0, 1'b1);
      directed(8'hFF, 8'd0,  8'hFF, 8'd0, 4'd0, 1'b0, 1'b0);
      drain();

      // Backpressure: two beats fill the pipe, the third waits at the input
      set_rdy(2);
      send(8'h03, 8'd9);
      send(8'h24, 8'd1);
      for (int k = 0; k < 3; k++) begin
         offer(8'h00, 8'd7, acc);
         chk("bp_ready_low", int'(acc), 0);
         chk("bp_valid_hold", int'(valid_o), 1);
         chk("bp_data_hold", int'(data_o), int'(exp_q[0].d));
      end
      set_rdy(1);
      send(8'h00, 8'd7);
      idle();
      drain();

      // Reset with both stages full discards everything
      set_rdy(2);
      send(8'h05, 8'd4);
      send(8'h40, 8'd6);
      @(negedge clk);
      valid_i = 1'b0;
      rst_n_i = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n_i = 1'b1;
      #2;
      chk("mid_rst_valid", int'(valid_o), 0);
      chk("mid_rst_ready", int'(ready_o), 1);
      chk("mid_rst_data",  int'(data_o),  0);
      chk("mid_rst_shift", int'(shift_o), 0);

      // Clock enable low freezes a beat sitting in stage 1
      set_rdy(1);
      send(8'h02, 8'd3);
      @(negedge clk);
      valid_i = 1'b0;
      cke_i   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("cke_valid_frozen", int'(valid_o), 0);
         chk("cke_ready_low", int'(ready_o), 0);
         @(negedge clk);
      end
      cke_i = 1'b1;
      drain();

      // Every data value, random exponents, random downstream readiness
      set_rdy(0);
      for (int d = 0; d < 256; d++) begin
         int e;
         e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
         send(8'(d), 8'(e));
      end
      idle();
      drain();
      @(negedge clk);
      #2;
      chk("final_empty", int'(valid_o), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
